// File: rtl/trigger_chain_cfg_sequencer.sv
// trigger_chain_cfg_sequencer
// Wishbone master that replays queued configuration writes into the
// 8-channel trigger chain target space. Commands {bcast, adr, dat} are
// pushed into a FIFO, then start_i drains them as single write cycles.
// Broadcast commands expand into one write per channel (adr[10:8] = 0..7).
// Optional build macro: CFG_SEQ_READBACK_EN adds a read-back verify of
// every acked write (state VERIFY).
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start_i
// LOAD   | pop FIFO head into holding register, pick first channel
// WRITE  | write cycle on the bus, waiting for ack/err/rty/timeout
// GAP    | one idle bus cycle before (re)issuing a cycle
// VERIFY | read-back of the just-acked write (readback build only)
// DONE   | one-cycle done pulse, then back to IDLE

module trigger_chain_cfg_sequencer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_bcast_i,
    input  logic [21:0]                   cmd_adr_i,
    input  logic [31:0]                   cmd_dat_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    input  logic                          err_clr_i,
    output logic [7:0]                    err_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic                          wbm_cyc_o,
    output logic                          wbm_stb_o,
    output logic                          wbm_we_o,
    output logic [21:0]                   wbm_adr_o,
    output logic [31:0]                   wbm_dat_o,
    output logic [3:0]                    wbm_sel_o,
    input  logic [31:0]                   wbm_dat_i,
    input  logic                          wbm_ack_i,
    input  logic                          wbm_err_i,
    input  logic                          wbm_rty_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int EW = 1 + 22 + 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
`ifdef CFG_SEQ_READBACK_EN
        ,S_VERIFY = 3'd5
`endif
    } state_t;

    state_t          state;

    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head;
    logic            push;
    logic            pop;

    logic            hold_bcast;
    logic [10:0]     hold_adr_hi;
    logic [7:0]      hold_adr_lo;
    logic [31:0]     hold_dat;
    logic [2:0]      ch;
    logic [TW-1:0]   tmo_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            cyc_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [7:0]      err_cnt_q;

    logic            in_bus;
    logic            rsp_err;
    logic            rsp_ack;
    logic            rsp_rty;
    logic            tmo_hit;
    logic            rty_fail;
    logic            xfer_fail;
    logic            xfer_ok;
    logic            more_ch;
    logic            fifo_avail;
    state_t          adv_state;

`ifdef CFG_SEQ_READBACK_EN
    logic            gap_rd;
    logic            rd_bad;
    logic            wr_acked;
`else
    logic            unused_rd;
    assign unused_rd = ^wbm_dat_i;
`endif

    assign cmd_ready_o = (count != CW'(FIFO_DEPTH));
    assign push        = cmd_valid_i & cmd_ready_o;
    assign pop         = (state == S_LOAD);
    assign head        = fifo_mem[rd_ptr];
    assign fifo_cnt_o  = count;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_adr_o   = {hold_adr_hi, ch, hold_adr_lo};
    assign wbm_dat_o   = hold_dat;
    assign wbm_sel_o   = 4'hF;
`ifdef CFG_SEQ_READBACK_EN
    assign wbm_we_o    = cyc_q & ~gap_rd;
`else
    assign wbm_we_o    = cyc_q;
`endif

    // FIFO storage; no reset needed, validity is tracked by count
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_bcast_i, cmd_adr_i, cmd_dat_i};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Bus response decode: err beats ack beats rty; silence on an expired
    // timer is a failure, as is one rty too many
    always_comb begin
        in_bus   = (state == S_WRITE);
`ifdef CFG_SEQ_READBACK_EN
        in_bus   = in_bus | (state == S_VERIFY);
`endif
        rsp_err  = in_bus & wbm_err_i;
        rsp_ack  = in_bus & ~wbm_err_i & wbm_ack_i;
        rsp_rty  = in_bus & ~wbm_err_i & ~wbm_ack_i & wbm_rty_i;
        tmo_hit  = in_bus & ~wbm_err_i & ~wbm_ack_i & ~wbm_rty_i & (tmo_cnt == '0);
        rty_fail = rsp_rty & (retry_cnt == RW'(MAX_RETRY));
`ifdef CFG_SEQ_READBACK_EN
        rd_bad    = (state == S_VERIFY) & rsp_ack & (wbm_dat_i != hold_dat);
        wr_acked  = (state == S_WRITE) & rsp_ack;
        xfer_fail = rsp_err | tmo_hit | rty_fail | rd_bad;
        xfer_ok   = (state == S_VERIFY) & rsp_ack & ~rd_bad;
`else
        xfer_fail = rsp_err | tmo_hit | rty_fail;
        xfer_ok   = rsp_ack;
`endif
    end

    // Where to go once the current write has completed or failed
    always_comb begin
        more_ch    = hold_bcast & (ch != 3'd7);
        fifo_avail = (count != '0) | push;
        if (more_ch)         adv_state = S_GAP;
        else if (fifo_avail) adv_state = S_LOAD;
        else                 adv_state = S_DONE;
    end

    // Sequencer FSM with registered bus strobes and status
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= S_IDLE;
            hold_bcast  <= 1'b0;
            hold_adr_hi <= '0;
            hold_adr_lo <= '0;
            hold_dat    <= '0;
            ch          <= '0;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CFG_SEQ_READBACK_EN
            gap_rd      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (count != '0) begin
                            state <= S_LOAD;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    hold_bcast  <= head[54];
                    hold_adr_hi <= head[53:43];
                    hold_adr_lo <= head[39:32];
                    hold_dat    <= head[31:0];
                    ch          <= head[54] ? 3'd0 : head[42:40];
                    retry_cnt   <= '0;
                    tmo_cnt     <= TW'(TIMEOUT_CYCLES);
                    cyc_q       <= 1'b1;
`ifdef CFG_SEQ_READBACK_EN
                    gap_rd      <= 1'b0;
`endif
                    state       <= S_WRITE;
                end
`ifdef CFG_SEQ_READBACK_EN
                S_WRITE, S_VERIFY: begin
`else
                S_WRITE: begin
`endif
                    if (xfer_fail || xfer_ok) begin
                        cyc_q  <= 1'b0;
                        state  <= adv_state;
                        done_q <= (adv_state == S_DONE);
`ifdef CFG_SEQ_READBACK_EN
                        gap_rd <= 1'b0;
`endif
                        if (more_ch) begin
                            ch        <= ch + 3'd1;
                            retry_cnt <= '0;
                        end
`ifdef CFG_SEQ_READBACK_EN
                    end else if (wr_acked) begin
                        cyc_q     <= 1'b0;
                        retry_cnt <= '0;
                        gap_rd    <= 1'b1;
                        state     <= S_GAP;
`endif
                    end else if (rsp_rty) begin
                        cyc_q     <= 1'b0;
                        retry_cnt <= retry_cnt + RW'(1);
                        state     <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                S_GAP: begin
                    tmo_cnt <= TW'(TIMEOUT_CYCLES);
                    cyc_q   <= 1'b1;
`ifdef CFG_SEQ_READBACK_EN
                    state   <= gap_rd ? S_VERIFY : S_WRITE;
`else
                    state   <= S_WRITE;
`endif
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    cyc_q  <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky error flag and saturating failure count; a new failure wins
    // over a coincident clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (xfer_fail) begin
            err_q <= 1'b1;
            if (err_clr_i)               err_cnt_q <= 8'd1;
            else if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end else if (err_clr_i) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end
    end

endmodule

// File: doc/trigger_chain_cfg_sequencer.md
Name: trigger_chain_cfg_sequencer

Overview:
- Wishbone master that sequences coefficient/AGC configuration writes into the 8-channel trigger chain target space (22-bit address; channel select at adr[10:8], register offset at adr[7:0]).
- Software pushes queued {broadcast, address, data} commands, then issues start. The block replays them as single Wishbone write cycles, in order.
- Handles ack/err/rty and timeout, and expands broadcast commands into 8 per-channel writes.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 255, cycles without ack/err/rty before a write is abandoned.
- MAX_RETRY, 3, rty responses tolerated per write before it counts as an error.

Ports:
- wb_clk_i  in  1  clock; all logic is on this clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command push request.
- cmd_ready_o  out  1  FIFO not full; a push occurs when valid&ready.
- cmd_bcast_i  in  1  1 = write to all 8 channels; cmd_adr_i[10:8] is ignored.
- cmd_adr_i  in  22  target address.
- cmd_dat_i  in  32  write data.
- start_i  in  1  single-cycle pulse; begins draining the FIFO.
- busy_o  out  1  high from the start-accept cycle until DONE is left.
- done_o  out  1  one-cycle pulse when the drain completes.
- err_o  out  1  sticky error flag.
- err_clr_i  in  1  clears err_o and err_cnt_o.
- err_cnt_o  out  8  failed-write count; saturates at 255.
- fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  occupancy.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  master strobes.
- wbm_adr_o  out  22  write address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte enables; always 4'hF.
- wbm_dat_i  in  32  read data; used only with the optional feature.
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  slave responses.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, except cmd_ready_o=1 and wbm_sel_o=4'hF.
  - FIFO empty; state IDLE.
- FIFO:
  - Push when cmd_valid_i&cmd_ready_o; pop only in LOAD.
  - Simultaneous push and pop: occupancy unchanged.
  - Push while full: ignored, nothing stored.
  - Pushes are allowed while busy; those entries are drained in the same run.
- FSM states: IDLE, LOAD, WRITE, GAP, DONE.
- IDLE:
  - start_i with FIFO non-empty -> LOAD, busy_o=1.
  - start_i with FIFO empty -> DONE directly; done_o still pulses one cycle later.
  - start_i while busy is ignored.
- LOAD:
  - Pop the head entry into a holding register.
  - ch = 0 if bcast, else cmd_adr[10:8].
  - Go to WRITE.
- WRITE:
  - cyc=stb=we=1; adr={cmd_adr[21:11], ch, cmd_adr[7:0]}; dat=cmd_dat.
  - Strobes stay held until a response or timeout. Response priority: err > ack > rty.
  - ack: write complete.
  - err, or timeout counter reaching TIMEOUT_CYCLES: write failed; err_o=1, err_cnt_o++.
  - rty: retry_cnt++ and go to GAP. If retry_cnt would exceed MAX_RETRY, the write fails instead.
- GAP:
  - One cycle with cyc=stb=0, then back to WRITE with the same address.
  - The timeout counter restarts.
- After a write completes or fails:
  - If bcast and ch<7: ch++, then GAP -> WRITE. A failed channel does not stop the others.
  - Otherwise: FIFO non-empty -> LOAD; empty -> DONE.
- DONE: done_o=1 for one cycle, busy_o drops, -> IDLE.
- Strobes are deasserted in the cycle after ack/err; there are no back-to-back cycles without an idle gap.
- Latency: start_i to first wbm_cyc_o = 2 cycles (IDLE->LOAD->WRITE).
- err_clr_i coincident with a new error: the error wins (err_o=1, count=1).
- Reset mid-cycle drops cyc immediately (async) and discards the FIFO contents.

Optional Feature:
- Macro: CFG_SEQ_READBACK_EN.
- When defined, each acked write is followed, after a GAP, by a read (we=0) to the same address in state VERIFY.
  - wbm_dat_i != written data -> write counts as failed.
  - Read err/timeout -> write counts as failed.
  - rty handling is identical to WRITE.
- When undefined: no VERIFY state, wbm_dat_i is unused, and wbm_we_o is 1 whenever cyc is asserted.

Test Plan:
- Push 3 non-bcast writes (0x000104/0xA5, 0x000208/0x5A, 0x00070C/0x1), slave acks in 1 cycle, pulse start -> 3 write cycles in order with exact adr/dat, done_o pulse, err_cnt_o=0, fifo_cnt_o=0.
- Push bcast adr 0x000310 dat 0xDEADBEEF -> 8 writes at 0x010,0x110,...,0x710 (ch increments), each with dat 0xDEADBEEF.
- Slave never responds, TIMEOUT_CYCLES=255, 1 command -> cyc held 256 cycles then dropped, err_o=1, err_cnt_o=1, done_o pulses.
- Slave answers rty 4 times, MAX_RETRY=3 -> 4 cycles separated by 1-cycle gaps, then failure, err_cnt_o=1; with rty only twice then ack -> err_o stays 0.
- Push FIFO_DEPTH+1 entries -> cmd_ready_o=0 after 16 pushes, 17th ignored; start -> exactly 16 writes.
- Assert wb_rst_ni low mid-WRITE -> wbm_cyc_o=0 in the same cycle, busy_o=0, fifo_cnt_o=0; readback build with slave returning 0x0 for written 0x1 -> err_cnt_o=1.
